add_pipe: RTL

Pipelined, parametrised adder/subtractor with carry-out and signed overflow. It is the multi-cycle successor of the single-cycle carry adder in the npc datapath. The carry chain is split into SEG_LEN-bit segments, with one segment resolved per stage, so wide operands (64-bit and up) meet timing. It uses a valid/ready handshake on both sides, a pass-through tag and a synchronous flush, and is used by the EXU for wide add/sub and by multi-word arithmetic.

---
 rtl/add_pipe_pkg.sv | 15 +
 rtl/add_pipe_if.sv | 37 +++
 rtl/add_pipe_seg.sv | 16 +
 rtl/add_pipe.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// Shared widths and helpers for the add_pipe slice.
// Defining ADD_PIPE_CMP_EN adds the registered slt/sltu compare outputs.
package add_pipe_pkg;

    localparam int XLEN         = 64;
    localparam int DEF_DATA_LEN = XLEN;
    localparam int DEF_SEG_LEN  = 16;
    localparam int DEF_TAG_LEN  = 4;

    // DATA_LEN must be a whole multiple of SEG_LEN.
    function automatic int seg_count(input int data_len, input int seg_len);
        return data_len / seg_len;
    endfunction

endpackage

// File: rtl/add_pipe_if.sv
// Request/result bus of add_pipe; master is the producer/consumer, slave is the adder.
interface add_pipe_if
    import add_pipe_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int TAG_LEN  = DEF_TAG_LEN
) ();

    // A transfer happens on a rising edge where valid && ready; valid never waits on ready,
    // and payload must stay stable while valid && ~ready.
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] op_a;
    logic [DATA_LEN-1:0] op_b;
    logic                sub;
    logic [TAG_LEN-1:0]  in_tag;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] sum;
    logic                cout;
    logic                overflow;
    logic [TAG_LEN-1:0]  out_tag;
    logic                slt;
    logic                sltu;

    modport master (
        output in_valid, op_a, op_b, sub, in_tag, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, out_tag, slt, sltu
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, in_tag, out_ready,
        output in_ready, out_valid, sum, cout, overflow, out_tag, slt, sltu
    );

endinterface

// File: rtl/add_pipe_seg.sv
// One SEG_LEN-bit slice of the carry chain: combinational add with carry in and out.
module add_pipe_seg
    import add_pipe_pkg::*;
#(
    parameter int SEG_LEN = DEF_SEG_LEN
) (
    input  logic [SEG_LEN-1:0] a_i,
    input  logic [SEG_LEN-1:0] b_i,
    input  logic               c_i,
    output logic [SEG_LEN-1:0] s_o,
    output logic               c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG_LEN{1'b0}}, c_i};

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/sub: one SEG_LEN carry segment resolved per stage, valid/ready on both sides.
// Optional slt/sltu outputs are built when ADD_PIPE_CMP_EN is defined.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int SEG_LEN  = DEF_SEG_LEN,
    parameter int TAG_LEN  = DEF_TAG_LEN
) (
    input logic       clk,
    input logic       rst,
    input logic       flush,
    add_pipe_if.slave bus
);

    localparam int NUM_SEG = seg_count(DATA_LEN, SEG_LEN);
    localparam int LAST    = NUM_SEG - 1;

    logic                st_valid [NUM_SEG];
    logic [DATA_LEN-1:0] st_word  [NUM_SEG];
    logic [DATA_LEN-1:0] st_b     [NUM_SEG];
    logic                st_carry [NUM_SEG];
    logic                st_sub   [NUM_SEG];
    logic [TAG_LEN-1:0]  st_tag   [NUM_SEG];
    logic                adv      [NUM_SEG];
    logic                load     [NUM_SEG];
    logic                in_ready;
    logic [DATA_LEN-1:0] b_eff;
    logic                ovf_q;

    // Ready ripples back from the consumer so bubbles collapse under backpressure.
    always_comb begin
        for (int k = 0; k < NUM_SEG; k++) begin
            adv[k]  = 1'b0;
            load[k] = 1'b0;
        end
        adv[LAST] = st_valid[LAST] & bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = st_valid[k] & (~st_valid[k+1] | adv[k+1]);
        end
        for (int k = 0; k < NUM_SEG; k++) begin
            load[k] = ~st_valid[k] | adv[k];
        end
    end

    assign in_ready     = ~flush & load[0];
    assign bus.in_ready = in_ready;
    assign b_eff        = bus.op_b ^ {DATA_LEN{bus.sub}};

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        logic [DATA_LEN-1:0] word_in, b_in, word_d, b_d;
        logic                cin, sub_in, vld_in;
        logic [TAG_LEN-1:0]  tag_in;
        logic [SEG_LEN-1:0]  seg_s;
        logic                seg_c;
        logic                vld_q, carry_q, sub_q;
        logic [DATA_LEN-1:0] word_q, b_q;
        logic [TAG_LEN-1:0]  tag_q;

        if (k == 0) begin : g_head
            assign word_in = bus.op_a;
            assign b_in    = b_eff;
            assign cin     = bus.sub;
            assign sub_in  = bus.sub;
            assign tag_in  = bus.in_tag;
            assign vld_in  = bus.in_valid;
        end else begin : g_body
            assign word_in = st_word[k-1];
            assign b_in    = st_b[k-1];
            assign cin     = st_carry[k-1];
            assign sub_in  = st_sub[k-1];
            assign tag_in  = st_tag[k-1];
            assign vld_in  = st_valid[k-1];
        end

        add_pipe_seg #(.SEG_LEN(SEG_LEN)) u_seg (
            .a_i (word_in[SEG_LEN-1:0]),
            .b_i (b_in[SEG_LEN-1:0]),
            .c_i (cin),
            .s_o (seg_s),
            .c_o (seg_c)
        );

        // word_q shifts right each stage: consumed A segments leave the bottom while
        // sum segments enter the top, so the last stage holds exactly the full sum.
        assign word_d = (word_in >> SEG_LEN) | (DATA_LEN'(seg_s) << (DATA_LEN - SEG_LEN));
        assign b_d    = b_in >> SEG_LEN;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (flush) begin
                vld_q <= 1'b0;
            end else if (load[k]) begin
                vld_q <= vld_in;
            end
        end

        if (k == LAST) begin : g_tail
            logic ovf_d;

            assign ovf_d = (word_in[SEG_LEN-1] == b_in[SEG_LEN-1]) &&
                           (seg_s[SEG_LEN-1] != word_in[SEG_LEN-1]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q  <= '0;
                    b_q     <= '0;
                    carry_q <= 1'b0;
                    sub_q   <= 1'b0;
                    tag_q   <= '0;
                    ovf_q   <= 1'b0;
                end else if (load[k]) begin
                    word_q  <= word_d;
                    b_q     <= b_d;
                    carry_q <= seg_c;
                    sub_q   <= sub_in;
                    tag_q   <= tag_in;
                    ovf_q   <= ovf_d;
                end
            end

`ifdef ADD_PIPE_CMP_EN
            logic slt_q, sltu_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slt_q  <= 1'b0;
                    sltu_q <= 1'b0;
                end else if (load[k]) begin
                    slt_q  <= sub_in & (seg_s[SEG_LEN-1] ^ ovf_d);
                    sltu_q <= sub_in & ~seg_c;
                end
            end

            assign bus.slt  = slt_q;
            assign bus.sltu = sltu_q;
`else
            assign bus.slt  = 1'b0;
            assign bus.sltu = 1'b0;
`endif
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (load[k]) begin
                    word_q  <= word_d;
                    b_q     <= b_d;
                    carry_q <= seg_c;
                    sub_q   <= sub_in;
                    tag_q   <= tag_in;
                end
            end
        end

        assign st_valid[k] = vld_q;
        assign st_word[k]  = word_q;
        assign st_b[k]     = b_q;
        assign st_carry[k] = carry_q;
        assign st_sub[k]   = sub_q;
        assign st_tag[k]   = tag_q;
    end

    assign bus.out_valid = st_valid[LAST];
    assign bus.sum       = st_word[LAST];
    assign bus.cout      = st_carry[LAST];
    assign bus.overflow  = ovf_q;
    assign bus.out_tag   = st_tag[LAST];

endmodule
